// File: rtl/perip_if.sv
// perip_if: core <-> data-side responder bus.
//   master : drives perip_addr/perip_wen/perip_mask/perip_wdata, samples perip_rdata
//   slave  : samples the request, drives perip_rdata combinationally
interface perip_if;
    logic [31:0] perip_addr;
    logic        perip_wen;
    logic [1:0]  perip_mask;
    logic [31:0] perip_wdata;
    logic [31:0] perip_rdata;

    modport master (
        output perip_addr, perip_wen, perip_mask, perip_wdata,
        input  perip_rdata
    );

    modport slave (
        input  perip_addr, perip_wen, perip_mask, perip_wdata,
        output perip_rdata
    );
endinterface

// File: rtl/perip_bridge.sv
// perip_bridge: decodes core loads/stores onto the data RAM and the board
// peripheral registers (switches, LEDs, seven-segment value, ms counter).
//   cpu_clk   : clock, all state updates on the rising edge
//   cpu_rst   : asynchronous active-low reset
//   bus       : perip_if.slave, zero-latency reads, stores commit on next edge
//   sw        : asynchronous board switches (2-flop synchronized)
//   led       : LED register
//   seg_wdata : seven-segment value register
module perip_bridge #(
    parameter int DRAM_WORDS = 4096,
    parameter int CNT_DIV    = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    perip_if.slave      bus,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [31:0] seg_wdata
);
    localparam int AW = $clog2(DRAM_WORDS);
    localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

    localparam logic [31:0] DRAM_BASE  = 32'h8010_0000;
    localparam logic [31:0] DRAM_BYTES = 32'(4 * DRAM_WORDS);
    localparam logic [31:0] SW_ADDR    = 32'h8020_0000;
    localparam logic [31:0] SEG_ADDR   = 32'h8020_0020;
    localparam logic [31:0] LED_ADDR   = 32'h8020_0040;
    localparam logic [31:0] CNT_ADDR   = 32'h8020_0050;
    localparam logic [31:0] CMD_RUN    = 32'h8000_0000;
    localparam logic [31:0] CMD_STOP   = 32'hFFFF_FFFF;

    // ---------------- address decode ----------------
    // Registers are word-sized; decode on the word address so byte and
    // halfword stores can reach every lane of SEG/LED.
    logic hit_dram, hit_sw, hit_seg, hit_led, hit_cnt;
    logic [AW-1:0] dram_idx;

    // Unsigned wrap makes this a single compare for the whole window.
    assign hit_dram = (bus.perip_addr - DRAM_BASE) < DRAM_BYTES;
    assign hit_sw   = bus.perip_addr[31:2] == SW_ADDR[31:2];
    assign hit_seg  = bus.perip_addr[31:2] == SEG_ADDR[31:2];
    assign hit_led  = bus.perip_addr[31:2] == LED_ADDR[31:2];
    assign hit_cnt  = bus.perip_addr[31:2] == CNT_ADDR[31:2];
    assign dram_idx = bus.perip_addr[2 +: AW];

    // ---------------- store lane placement ----------------
    // off is the lane the store data starts at; the ignored low address
    // bits for halfword/word are dropped from it too.
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wd;

    always_comb begin
        off = '0;
        be  = '0;
        case (bus.perip_mask)
            2'b00: begin
                off = bus.perip_addr[1:0];
                be  = 4'b0001 << off;
            end
            2'b01: begin
                off = {bus.perip_addr[1], 1'b0};
                be  = 4'b0011 << off;
            end
            default: begin
                off = 2'b00;
                be  = 4'b1111;
            end
        endcase
    end

    assign wd = bus.perip_wdata << {off, 3'b000};

    // ---------------- DRAM (async read, no reset) ----------------
    logic [31:0] dram [DRAM_WORDS];

    always_ff @(posedge cpu_clk) begin
        if (bus.perip_wen && hit_dram) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) dram[dram_idx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    // ---------------- SEG / LED / switch synchronizer ----------------
    logic [15:0] sw_meta, sw_sync;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            led       <= '0;
            seg_wdata <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (bus.perip_wen && hit_seg) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) seg_wdata[8*i +: 8] <= wd[8*i +: 8];
            end
            // LED is 16 bits wide: lanes 2/3 have nowhere to land.
            if (bus.perip_wen && hit_led) begin
                for (int i = 0; i < 2; i++)
                    if (be[i]) led[8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // ---------------- millisecond counter ----------------
    typedef enum logic {CNT_IDLE, CNT_RUN} cnt_state_t;

    cnt_state_t    state, state_n;
    logic [31:0]   cnt, cnt_n;
    logic [PW-1:0] pre, pre_n;
    logic          cmd_run, cmd_stop;

    assign cmd_run  = bus.perip_wen && hit_cnt && (bus.perip_wdata == CMD_RUN);
    assign cmd_stop = bus.perip_wen && hit_cnt && (bus.perip_wdata == CMD_STOP);

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state <= CNT_IDLE;
            cnt   <= '0;
            pre   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pre   <= pre_n;
        end
    end

    // Commands are checked first so a command on a tick edge drops the tick.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pre_n   = pre;
        if (cmd_run) begin
            state_n = CNT_RUN;
            cnt_n   = '0;
            pre_n   = '0;
        end else if (cmd_stop) begin
            state_n = CNT_IDLE;
        end else if (state == CNT_RUN) begin
            if (pre == PW'(CNT_DIV - 1)) begin
                pre_n = '0;
                cnt_n = cnt + 32'd1;
            end else begin
                pre_n = pre + PW'(1);
            end
        end
    end

    // ---------------- read mux (never masked) ----------------
    always_comb begin
        bus.perip_rdata = '0;
        if (hit_dram)     bus.perip_rdata = dram[dram_idx];
        else if (hit_sw)  bus.perip_rdata = {16'h0000, sw_sync};
        else if (hit_seg) bus.perip_rdata = seg_wdata;
        else if (hit_led) bus.perip_rdata = {16'h0000, led};
        else if (hit_cnt) bus.perip_rdata = cnt;
    end
endmodule

// File: tb/tb_perip_bridge.sv
module tb_perip_bridge;
    localparam int DIV = 4;
    localparam logic [31:0] DB   = 32'h8010_0000;
    localparam logic [31:0] SWA  = 32'h8020_0000;
    localparam logic [31:0] SEGA = 32'h8020_0020;
    localparam logic [31:0] LEDA = 32'h8020_0040;
    localparam logic [31:0] CNTA = 32'h8020_0050;
    localparam logic [31:0] RUN  = 32'h8000_0000;
    localparam logic [31:0] STOP = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic [15:0] led;
    logic [31:0] seg_wdata;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    perip_if bus ();

    perip_bridge #(.DRAM_WORDS(1024), .CNT_DIV(DIV)) dut (
        .cpu_clk   (clk),
        .cpu_rst   (rst_n),
        .bus       (bus),
        .sw        (sw),
        .led       (led),
        .seg_wdata (seg_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // DRAM model covers the first 64 bytes, the only region the bench touches.
    logic [7:0]  dm [64];
    logic [15:0] led_m = '0;
    logic [31:0] seg_m = '0;
    logic [15:0] sw_m  = '0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        int b;
        w = a & ~32'h3;
        if (w >= DB && w < DB + 64) begin
            b = int'(w - DB);
            return {dm[b+3], dm[b+2], dm[b+1], dm[b]};
        end
        if (w == SWA)  return {16'h0, sw_m};
        if (w == SEGA) return seg_m;
        if (w == LEDA) return {16'h0, led_m};
        return 32'h0;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
        logic [31:0] w;
        logic [7:0]  b;
        int off, n, lane;
        w = a & ~32'h3;
        case (m)
            2'd0:    begin off = int'(a % 4);     n = 1; end
            2'd1:    begin off = int'(a % 4) & 2; n = 2; end
            default: begin off = 0;               n = 4; end
        endcase
        for (int k = 0; k < n; k++) begin
            b = 8'(d >> (8 * k));
            lane = off + k;
            if (w >= DB && w < DB + 64) dm[int'(w - DB) + lane] = b;
            else if (w == SEGA)         seg_m[8*lane +: 8] = b;
            else if (w == LEDA && lane < 2) led_m[8*lane +: 8] = b;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic w, input logic [1:0] m, input logic [31:0] d);
        bus.perip_addr  = a;
        bus.perip_wen   = w;
        bus.perip_mask  = m;
        bus.perip_wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        put(a, 1'b0, 2'd2, 32'h0);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
        put(a, 1'b1, m, d);
        step();
        m_write(a, m, d);
        bus.perip_wen = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] a, d, cbase, frozen;
        logic [1:0]  m;
        logic        w;
        int          e0, toff, ks, sel;

        rst_n = 1'b0;
        sw    = 16'h0;
        put(32'h0, 1'b0, 2'd2, 32'h0);
        #1;
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_seg", seg_wdata, 32'h0);
        rd(SWA);  chk("rst_sw_rd",  bus.perip_rdata, 32'h0);
        rd(LEDA); chk("rst_led_rd", bus.perip_rdata, 32'h0);
        rd(SEGA); chk("rst_seg_rd", bus.perip_rdata, 32'h0);
        rd(CNTA); chk("rst_cnt_rd", bus.perip_rdata, 32'h0);
        step(); step();
        rst_n = 1'b1;
        step();

        // DRAM lane placement
        for (int i = 0; i < 16; i++) store(DB + 32'(4 * i), 2'd2, $urandom);
        store(DB + 8,  2'd2, 32'h1122_3344);
        store(DB + 9,  2'd0, 32'h0000_00AB);
        store(DB + 10, 2'd1, 32'h0000_BEEF);
        rd(DB + 8); chk("dram_lanes", bus.perip_rdata, 32'hBEEF_AB44);
        chk("dram_lanes_model", bus.perip_rdata, m_read(DB + 8));

        // same-cycle read/write hazard
        store(DB, 2'd2, 32'h5555_AAAA);
        put(DB, 1'b1, 2'd2, 32'h0BAD_F00D);
        #1; chk("hazard_old", bus.perip_rdata, 32'h5555_AAAA);
        step(); m_write(DB, 2'd2, 32'h0BAD_F00D);
        rd(DB); chk("hazard_new", bus.perip_rdata, 32'h0BAD_F00D);

        // LED / SEG
        put(LEDA, 1'b1, 2'd2, 32'h0000_A5A5);
        #1; chk("led_before_edge", {16'h0, led}, 32'h0);
        step(); m_write(LEDA, 2'd2, 32'h0000_A5A5);
        chk("led_after_edge", {16'h0, led}, 32'h0000_A5A5);
        rd(LEDA); chk("led_rd", bus.perip_rdata, 32'h0000_A5A5);
        store(LEDA + 1, 2'd0, 32'h3C);
        chk("led_byte1", {16'h0, led}, 32'h0000_3CA5);
        store(LEDA + 2, 2'd1, 32'hFFFF);
        chk("led_upper_half", {16'h0, led}, 32'h0000_3CA5);
        store(SEGA, 2'd2, 32'hDEAD_BEEF);
        store(SEGA + 1, 2'd0, 32'h12);
        chk("seg_byte", seg_wdata, 32'hDEAD_12EF);

        // switch synchronizer
        sw = 16'h0F0F; sw_m = 16'h0F0F;
        step(); step(); step();
        rd(SWA); chk("sw_3rd_edge", bus.perip_rdata, 32'h0000_0F0F);
        store(SWA, 2'd2, 32'h1234_5678);
        rd(SWA); chk("sw_write_ignored", bus.perip_rdata, 32'h0000_0F0F);

        // unmapped
        rd(32'h8030_0000); chk("unmapped_rd", bus.perip_rdata, 32'h0);
        store(32'h8030_0000, 2'd2, 32'hFFFF_FFFF);
        rd(32'h8030_0000); chk("unmapped_rd2", bus.perip_rdata, 32'h0);
        chk("unmapped_led", {16'h0, led}, {16'h0, led_m});
        chk("unmapped_seg", seg_wdata, seg_m);

        // randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = DB + 32'($urandom_range(0, 63));
            else if (sel == 6) a = LEDA + 32'($urandom_range(0, 3));
            else if (sel == 7) a = SEGA + 32'($urandom_range(0, 3));
            else if (sel == 8) a = SWA + 32'($urandom_range(0, 3));
            else               a = 32'h8030_0000 + 32'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            if (m == 2'd1) a[0] = 1'b0;
            if (m[1])      a[1:0] = 2'b00;
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            put(a, w, m, d);
            #1; chk("rand_rd", bus.perip_rdata, m_read(a));
            step();
            if (w) m_write(a, m, d);
            chk("rand_led", {16'h0, led}, {16'h0, led_m});
            chk("rand_seg", seg_wdata, seg_m);
        end
        bus.perip_wen = 1'b0;

        // counter: value after k edges of RUN is k / DIV
        put(CNTA, 1'b1, 2'd0, RUN); step(); e0 = cyc;
        rd(CNTA); chk("cnt_start", bus.perip_rdata, 32'h0);
        for (int i = 0; i < 23; i++) begin
            step(); rd(CNTA);
            chk("cnt_run", bus.perip_rdata, 32'((cyc - e0) / DIV));
        end
        // stop lands on a tick edge (k = 24): the tick is dropped
        put(CNTA, 1'b1, 2'd2, STOP); step(); ks = cyc - e0;
        frozen = 32'((ks - 1) / DIV);
        bus.perip_wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(); rd(CNTA); chk("cnt_hold", bus.perip_rdata, frozen);
        end
        put(CNTA, 1'b1, 2'd2, 32'h1234); step(); bus.perip_wen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(); rd(CNTA); chk("cnt_bad_cmd", bus.perip_rdata, frozen);
        end
        // restart, then restart again exactly on a tick edge
        put(CNTA, 1'b1, 2'd2, RUN); step(); e0 = cyc; bus.perip_wen = 1'b0;
        rd(CNTA); chk("cnt_restart", bus.perip_rdata, 32'h0);
        step(); step(); step();
        rd(CNTA); chk("cnt_pre_tick", bus.perip_rdata, 32'h0);
        put(CNTA, 1'b1, 2'd2, RUN); step(); e0 = cyc; bus.perip_wen = 1'b0;
        rd(CNTA); chk("cnt_cmd_beats_tick", bus.perip_rdata, 32'h0);
        step(); step();

        // wrap
        force dut.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cnt;
        cbase = 32'hFFFF_FFFF;
        toff = (cyc - e0) / DIV;
        rd(CNTA); chk("cnt_forced", bus.perip_rdata, cbase);
        for (int i = 0; i < 8; i++) begin
            step(); rd(CNTA);
            chk("cnt_wrap", bus.perip_rdata, cbase + 32'((cyc - e0) / DIV - toff));
        end

        // reset mid-run
        #2 rst_n = 1'b0;
        #1;
        led_m = '0; seg_m = '0;
        chk("midrst_led", {16'h0, led}, 32'h0);
        chk("midrst_seg", seg_wdata, 32'h0);
        rd(CNTA); chk("midrst_cnt", bus.perip_rdata, 32'h0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); rd(CNTA); chk("midrst_cnt_idle", bus.perip_rdata, 32'h0);
        end
        rd(DB + 8); chk("midrst_dram", bus.perip_rdata, m_read(DB + 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
